// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg: definitions shared by the receive depacketizer and the
// transmit packetizer.
//   SYNC_WORD_DEFAULT : frame sync pattern, transmitted MSB first
//   SYNC_W / HDR_LEN_W: sync pattern width and header length-field width
//   rx_state_t        : receive framing states
//   popcount32        : number of set bits in a 32-bit word
package rx_pkt_pkg;

    localparam int          SYNC_W            = 32;
    localparam int          HDR_LEN_W         = 16;
    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h1ACF_FC1D;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2
    } rx_state_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sync_correlator.sv
// sync_correlator: combinational tolerant match of a 32-bit window against
// a sync pattern and against its bitwise complement.
//   word       in  32  candidate window, MSB = oldest bit
//   match_norm out 1   window differs from PATTERN in at most MAX_ERR bits
//   match_inv  out 1   window differs from ~PATTERN in at most MAX_ERR bits
module sync_correlator
    import rx_pkt_pkg::*;
#(
    parameter logic [31:0] PATTERN = SYNC_WORD_DEFAULT,
    parameter int          MAX_ERR = 2
) (
    input  logic [31:0] word,
    output logic        match_norm,
    output logic        match_inv
);

    localparam logic [5:0] MAX_ERR_W = 6'(MAX_ERR);

    logic [5:0] err_norm_s;
    logic [5:0] err_inv_s;

    // Hamming distance to both polarities and threshold compare.
    always_comb begin
        err_norm_s = popcount32(word ^ PATTERN);
        err_inv_s  = popcount32(word ^ ~PATTERN);
        match_norm = (err_norm_s <= MAX_ERR_W);
        match_inv  = (err_inv_s <= MAX_ERR_W);
    end

endmodule

// File: rtl/depacketizer.sv
// depacketizer: hunts a serial bit stream for the frame sync word (either
// polarity), parses the 16-bit length header and emits the payload as a
// byte-wide AXI-Stream with a single-entry output register.
//   clk_32M768/rst_32M768   clock and async active-high reset
//   ce_bit, rx_valid        a bit is taken when both are high
//   rx_serial               demodulated hard bit
//   m_axis_*                payload byte stream (tuser = first, tlast = last)
//   payload_length          length latched at end of a good header
//   sync_inv                current frame was received inverted
//   pkt_done/hdr_err/ovf    one-cycle status pulses
module depacketizer
    import rx_pkt_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int          MAX_ERR   = 2,
    parameter logic [15:0] MAX_LEN   = 16'd1024
) (
    input  logic                 clk_32M768,
    input  logic                 rst_32M768,
    input  logic                 ce_bit,
    input  logic                 rx_serial,
    input  logic                 rx_valid,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [HDR_LEN_W-1:0] payload_length,
    output logic                 sync_inv,
    output logic                 pkt_done,
    output logic                 hdr_err,
    output logic                 ovf
);

    // Only the 31 older bits are stored; the 32-bit window is completed by
    // the incoming bit so the match is seen on the edge taking the last bit.
    logic [SYNC_W-2:0]    shift_r;
    logic [HDR_LEN_W-2:0] len_sh_r;
    logic [6:0]           byte_sh_r;
    logic [3:0]           len_cnt_r;
    logic [2:0]           bit_cnt_r;
    logic [HDR_LEN_W-1:0] byte_cnt_r;
    rx_state_t            state_r;

    logic [7:0]           tdata_r;
    logic                 tvalid_r;
    logic                 tlast_r;
    logic                 tuser_r;
    logic [HDR_LEN_W-1:0] payload_length_r;
    logic                 sync_inv_r;
    logic                 pkt_done_r;
    logic                 hdr_err_r;
    logic                 ovf_r;

    logic                 bit_acc_s;
    logic                 data_bit_s;
    logic [SYNC_W-1:0]    window_s;
    logic [HDR_LEN_W-1:0] len_next_s;
    logic [7:0]           byte_next_s;
    logic                 is_last_s;
    logic                 match_norm_s;
    logic                 match_inv_s;

    // Bit-level helpers derived from the current input and state.
    always_comb begin
        bit_acc_s   = ce_bit && rx_valid;
        data_bit_s  = rx_serial ^ sync_inv_r;
        window_s    = {shift_r, rx_serial};
        len_next_s  = {len_sh_r, data_bit_s};
        byte_next_s = {byte_sh_r, data_bit_s};
        is_last_s   = (byte_cnt_r == (payload_length_r - 16'd1));
    end

    sync_correlator #(
        .PATTERN (SYNC_WORD),
        .MAX_ERR (MAX_ERR)
    ) u_sync_correlator (
        .word       (window_s),
        .match_norm (match_norm_s),
        .match_inv  (match_inv_s)
    );

    // Framing state machine, header parse and output register.
    always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
        if (rst_32M768) begin
            shift_r          <= '0;
            len_sh_r         <= '0;
            byte_sh_r        <= 7'd0;
            len_cnt_r        <= 4'd0;
            bit_cnt_r        <= 3'd0;
            byte_cnt_r       <= 16'd0;
            state_r          <= HUNT;
            tdata_r          <= 8'd0;
            tvalid_r         <= 1'b0;
            tlast_r          <= 1'b0;
            tuser_r          <= 1'b0;
            payload_length_r <= 16'd0;
            sync_inv_r       <= 1'b0;
            pkt_done_r       <= 1'b0;
            hdr_err_r        <= 1'b0;
            ovf_r            <= 1'b0;
        end else begin
            pkt_done_r <= tvalid_r && m_axis_tready && tlast_r;
            hdr_err_r  <= 1'b0;
            ovf_r      <= 1'b0;
            // A handshake frees the register; a byte loaded below overrides.
            if (tvalid_r && m_axis_tready) begin
                tvalid_r <= 1'b0;
            end
            if (bit_acc_s) begin
                shift_r <= window_s[SYNC_W-2:0];
                case (state_r)
                    HUNT: begin
                        // Normal polarity takes precedence if both match.
                        if (match_norm_s) begin
                            sync_inv_r <= 1'b0;
                            len_cnt_r  <= 4'd0;
                            state_r    <= LEN;
                        end else if (match_inv_s) begin
                            sync_inv_r <= 1'b1;
                            len_cnt_r  <= 4'd0;
                            state_r    <= LEN;
                        end else begin
                            state_r <= HUNT;
                        end
                    end
                    LEN: begin
                        len_sh_r  <= len_next_s[HDR_LEN_W-2:0];
                        len_cnt_r <= len_cnt_r + 4'd1;
                        if (len_cnt_r == 4'd15) begin
                            if ((len_next_s == 16'd0) || (len_next_s > MAX_LEN)) begin
                                hdr_err_r <= 1'b1;
                                state_r   <= HUNT;
                            end else begin
                                payload_length_r <= len_next_s;
                                bit_cnt_r        <= 3'd0;
                                byte_cnt_r       <= 16'd0;
                                state_r          <= PAYLOAD;
                            end
                        end else begin
                            state_r <= LEN;
                        end
                    end
                    PAYLOAD: begin
                        byte_sh_r <= byte_next_s[6:0];
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            // Overrun: keep the pending byte, drop the new one.
                            if (tvalid_r && !m_axis_tready) begin
                                ovf_r   <= 1'b1;
                                state_r <= HUNT;
                            end else begin
                                tdata_r    <= byte_next_s;
                                tvalid_r   <= 1'b1;
                                tuser_r    <= (byte_cnt_r == 16'd0);
                                tlast_r    <= is_last_s;
                                byte_cnt_r <= byte_cnt_r + 16'd1;
                                state_r    <= is_last_s ? HUNT : PAYLOAD;
                            end
                        end else begin
                            state_r <= PAYLOAD;
                        end
                    end
                    default: begin
                        state_r <= HUNT;
                    end
                endcase
            end
        end
    end

    assign m_axis_tdata   = tdata_r;
    assign m_axis_tvalid  = tvalid_r;
    assign m_axis_tlast   = tlast_r;
    assign m_axis_tuser   = tuser_r;
    assign payload_length = payload_length_r;
    assign sync_inv       = sync_inv_r;
    assign pkt_done       = pkt_done_r;
    assign hdr_err        = hdr_err_r;
    assign ovf            = ovf_r;

endmodule

// File: tb/tb_depacketizer.sv
// tb_depacketizer: directed frames with a scoreboard queue of expected
// beats and a monitor that pops and compares on every AXI handshake.
module tb_depacketizer;
    import rx_pkt_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_bit = 1'b0;
    logic        rx_serial = 1'b0;
    logic        rx_valid = 1'b0;
    logic        tready = 1'b1;
    logic [7:0]  tdata;
    logic        tvalid, tlast, tuser;
    logic [15:0] payload_length;
    logic        sync_inv, pkt_done, hdr_err, ovf;

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    int    hdr_cnt = 0;
    int    ovf_cnt = 0;
    logic  done_exp = 1'b0;
    logic  inv_tx = 1'b0;

    localparam logic [31:0] SYNC = 32'h1ACF_FC1D;

    depacketizer dut (
        .clk_32M768     (clk),
        .rst_32M768     (rst),
        .ce_bit         (ce_bit),
        .rx_serial      (rx_serial),
        .rx_valid       (rx_valid),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tlast   (tlast),
        .m_axis_tuser   (tuser),
        .payload_length (payload_length),
        .sync_inv       (sync_inv),
        .pkt_done       (pkt_done),
        .hdr_err        (hdr_err),
        .ovf            (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic u, input logic l);
        beat_t b;
        b.data = d;
        b.user = u;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Monitor: samples 1 ns after the falling edge, away from the active edge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                done_exp = 1'b0;
            end else begin
                if (done_exp || pkt_done) check("pkt_done_timing", {31'd0, pkt_done}, {31'd0, done_exp});
                if (pkt_done) done_cnt++;
                if (hdr_err) hdr_cnt++;
                if (ovf) ovf_cnt++;
                done_exp = tvalid && tready && tlast;
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got tdata %0h tuser %0b tlast %0b, expected no beat",
                                 tdata, tuser, tlast);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", {24'd0, tdata}, {24'd0, e.data});
                        check("tuser", {31'd0, tuser}, {31'd0, e.user});
                        check("tlast", {31'd0, tlast}, {31'd0, e.last});
                    end
                end
            end
        end
    end

    // One bit period = 4 clocks, with decoy cycles that must not be taken.
    task automatic send_bit(input logic b);
        logic bb;
        bb = b ^ inv_tx;
        @(negedge clk); ce_bit = 1'b0; rx_valid = 1'b1; rx_serial = ~bb;
        @(negedge clk); ce_bit = 1'b1; rx_valid = 1'b0;
        @(negedge clk); rx_valid = 1'b1; rx_serial = bb;
        @(negedge clk); ce_bit = 1'b0; rx_valid = 1'b0; rx_serial = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(inv_tx);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, {31'd0, tvalid}, 32'd0);
        check({tag, "_tlast"}, {31'd0, tlast}, 32'd0);
        check({tag, "_tuser"}, {31'd0, tuser}, 32'd0);
        check({tag, "_tdata"}, {24'd0, tdata}, 32'd0);
        check({tag, "_pkt_done"}, {31'd0, pkt_done}, 32'd0);
        check({tag, "_hdr_err"}, {31'd0, hdr_err}, 32'd0);
        check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
        check({tag, "_sync_inv"}, {31'd0, sync_inv}, 32'd0);
        check({tag, "_payload_length"}, {16'd0, payload_length}, 32'd0);
    endtask

    initial begin
        int d0, h0, o0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        // Clean frame
        d0 = done_cnt;
        push_exp(8'hA5, 1'b1, 1'b0);
        push_exp(8'h3C, 1'b0, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b1);
        send_word(SYNC, 32); send_word(32'd3, 16);
        send_word(32'hA5, 8); send_word(32'h3C, 8); send_word(32'hFF, 8);
        idle(4);
        check("clean_len", {16'd0, payload_length}, 32'd3);
        check("clean_inv", {31'd0, sync_inv}, 32'd0);
        check("clean_done", done_cnt - d0, 32'd1);
        check("clean_q", exp_q.size(), 32'd0);

        // Inverted frame
        d0 = done_cnt;
        inv_tx = 1'b1;
        push_exp(8'hA5, 1'b1, 1'b0);
        push_exp(8'h3C, 1'b0, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b1);
        idle(4);
        send_word(SYNC, 32); send_word(32'd3, 16);
        send_word(32'hA5, 8); send_word(32'h3C, 8); send_word(32'hFF, 8);
        idle(4);
        inv_tx = 1'b0;
        check("inv_flag", {31'd0, sync_inv}, 32'd1);
        check("inv_len", {16'd0, payload_length}, 32'd3);
        check("inv_done", done_cnt - d0, 32'd1);
        check("inv_q", exp_q.size(), 32'd0);
        idle(4);

        // Sync with 2 bit errors: accepted
        push_exp(8'h81, 1'b1, 1'b1);
        send_word(SYNC ^ 32'h0200_0020, 32); send_word(32'd1, 16); send_word(32'h81, 8);
        idle(4);
        check("err2_inv", {31'd0, sync_inv}, 32'd0);
        check("err2_len", {16'd0, payload_length}, 32'd1);
        check("err2_q", exp_q.size(), 32'd0);

        // Sync with 3 bit errors: ignored
        d0 = done_cnt; h0 = hdr_cnt;
        send_word(SYNC ^ 32'h0010_0401, 32); send_word(32'd2, 16);
        send_word(32'h81, 8); send_word(32'h7E, 8);
        idle(4);
        check("err3_len", {16'd0, payload_length}, 32'd1);
        check("err3_done", done_cnt - d0, 32'd0);
        check("err3_hdr", hdr_cnt - h0, 32'd0);

        // Bad headers, then a good frame
        h0 = hdr_cnt;
        send_word(SYNC, 32); send_word(32'd0, 16);
        idle(4);
        check("hdr_len0", hdr_cnt - h0, 32'd1);
        send_word(SYNC, 32); send_word(32'd1025, 16);
        idle(4);
        check("hdr_len1025", hdr_cnt - h0, 32'd2);
        check("hdr_len_kept", {16'd0, payload_length}, 32'd1);
        push_exp(8'h5A, 1'b1, 1'b0);
        push_exp(8'hC3, 1'b0, 1'b1);
        send_word(SYNC, 32); send_word(32'd2, 16);
        send_word(32'h5A, 8); send_word(32'hC3, 8);
        idle(4);
        check("post_hdr_len", {16'd0, payload_length}, 32'd2);
        check("post_hdr_q", exp_q.size(), 32'd0);

        // Backpressure / overrun
        d0 = done_cnt; o0 = ovf_cnt;
        tready = 1'b0;
        push_exp(8'hA5, 1'b1, 1'b0);
        send_word(SYNC, 32); send_word(32'd3, 16); send_word(32'hA5, 8);
        send_word(32'h3C, 8); send_bit(1'b1);
        check("bp_ovf", ovf_cnt - o0, 32'd1);
        check("bp_tvalid", {31'd0, tvalid}, 32'd1);
        check("bp_tdata", {24'd0, tdata}, 32'hA5);
        check("bp_tuser", {31'd0, tuser}, 32'd1);
        check("bp_tlast", {31'd0, tlast}, 32'd0);
        tready = 1'b1;
        send_word(32'h7F, 7);
        idle(4);
        check("bp_q", exp_q.size(), 32'd0);
        check("bp_done", done_cnt - d0, 32'd0);
        check("bp_ovf_once", ovf_cnt - o0, 32'd1);

        // Reset mid-payload
        d0 = done_cnt;
        push_exp(8'hA5, 1'b1, 1'b0);
        send_word(SYNC, 32); send_word(32'd3, 16); send_word(32'hA5, 8);
        send_word(32'h1, 3);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_word(32'h1C, 5); send_word(32'hFF, 8);
        idle(4);
        check("midrst_q", exp_q.size(), 32'd0);
        check("midrst_done", done_cnt - d0, 32'd0);
        push_exp(8'hA5, 1'b1, 1'b0);
        push_exp(8'h3C, 1'b0, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b1);
        send_word(SYNC, 32); send_word(32'd3, 16);
        send_word(32'hA5, 8); send_word(32'h3C, 8); send_word(32'hFF, 8);
        idle(4);
        check("after_rst_len", {16'd0, payload_length}, 32'd3);
        check("after_rst_done", done_cnt - d0, 32'd1);

        repeat (10) @(negedge clk);
        check("final_q", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
